// File: rtl/pb_arbiter_if.sv
// pb_arbiter_if: handshake bundle between the button arbiter and the game logic.
interface pb_arbiter_if #(parameter int N = 2);
    localparam int WW = (N > 2) ? $clog2(N) : 1;
    logic          clr;
    logic          arm;
    logic [N-1:0]  pb;
    logic          push;
    logic          armed;
    logic          valid;
    logic [WW-1:0] winner;
    logic [N-1:0]  winner_onehot;
    logic          tie;
    logic          timeout;
    logic [N-1:0]  false_start;
    modport master (output clr, arm, pb,
                    input push, armed, valid, winner, winner_onehot, tie, timeout, false_start);
    modport slave  (input clr, arm, pb,
                    output push, armed, valid, winner, winner_onehot, tie, timeout, false_start);
endinterface

// File: rtl/pb_arbiter.sv
// pb_arbiter: N-player first-press arbiter with sync, edge detect, tie and timeout.
// Optional PBA_FALSE_START_EN: sticky per-channel flags for presses made while idle.
module pb_arbiter #(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input logic clk,
    input logic rst,
    pb_arbiter_if.slave bus
);
    localparam int WW = (N > 2) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, DECIDED, TIMED_OUT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sync [SYNC_STAGES];
    logic [N-1:0]  s, prev, e, mask, el;

    assign s  = sync[SYNC_STAGES-1];
    assign el = e & ~mask;

    function automatic logic [WW-1:0] lowest(input logic [N-1:0] v);
        lowest = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) lowest = WW'(i);
    endfunction

    // Edge is registered, so a press reaches the FSM SYNC_STAGES+1 cycles after sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            prev     <= '0;
            e        <= '0;
            bus.push <= 1'b0;
        end else begin
            sync[0] <= bus.pb;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            prev     <= s;
            e        <= s & ~prev;
            bus.push <= |s;
        end
    end

`ifdef PBA_FALSE_START_EN
    logic [N-1:0] fs;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fs <= '0;
        else if (bus.clr)
            fs <= '0;
        else if (state == IDLE)
            fs <= fs | e;
    end
    assign mask            = fs;
    assign bus.false_start = fs;
`else
    assign mask            = '0;
    assign bus.false_start = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.clr) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.armed         <= 1'b0;
            bus.valid         <= 1'b0;
            bus.timeout       <= 1'b0;
            bus.tie           <= 1'b0;
            bus.winner        <= '0;
            bus.winner_onehot <= '0;
        end else begin
            case (state)
                IDLE: if (bus.arm) begin
                    state     <= ARMED;
                    cnt       <= '0;
                    bus.armed <= 1'b1;
                end
                ARMED: if (|el) begin
                    state             <= DECIDED;
                    bus.armed         <= 1'b0;
                    bus.valid         <= 1'b1;
                    bus.winner_onehot <= el;
                    bus.winner        <= lowest(el);
                    bus.tie           <= |(el & (el - 1'b1));
                end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
                    state       <= TIMED_OUT;
                    bus.armed   <= 1'b0;
                    bus.timeout <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pb_arbiter.sv
// tb_pb_arbiter: directed checks of pb_arbiter with N=4, SYNC_STAGES=2, TIMEOUT=8.
module tb_pb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pb_arbiter_if #(.N(4)) bus ();
    pb_arbiter #(.N(4), .SYNC_STAGES(2), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm_round();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic clear(input int settle);
        bus.pb  = '0;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        tick(settle);
    endtask

    initial begin
        rst = 1'b1; bus.clr = 1'b0; bus.arm = 1'b0; bus.pb = '0;
        tick(2);
        rst = 1'b0;
        tick();
        chk("rst_armed", bus.armed, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_onehot", bus.winner_onehot, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_push", bus.push, 0);

        // single press on channel 2
        arm_round();
        chk("arm_armed", bus.armed, 1);
        bus.pb = 4'b0100;
        tick(3);
        chk("single_early", bus.valid, 0);
        tick();
        chk("single_valid", bus.valid, 1);
        chk("single_winner", bus.winner, 2);
        chk("single_onehot", bus.winner_onehot, 4'b0100);
        chk("single_tie", bus.tie, 0);
        chk("single_armed", bus.armed, 0);
        chk("single_push", bus.push, 1);
        bus.pb = 4'b1111;
        tick(5);
        chk("hold_winner", bus.winner, 2);
        chk("hold_onehot", bus.winner_onehot, 4'b0100);
        clear(0);
        chk("clr_valid", bus.valid, 0);
        chk("clr_winner", bus.winner, 0);
        chk("clr_onehot", bus.winner_onehot, 0);
        tick(4);

        // simultaneous presses on channels 1 and 3
        arm_round();
        bus.pb = 4'b1010;
        tick(4);
        chk("tie_valid", bus.valid, 1);
        chk("tie_tie", bus.tie, 1);
        chk("tie_winner", bus.winner, 1);
        chk("tie_onehot", bus.winner_onehot, 4'b1010);
        clear(0);
        chk("clr_tie", bus.tie, 0);
        tick(4);

        // unanswered round
        arm_round();
        tick(7);
        chk("to_early", bus.timeout, 0);
        chk("to_early_armed", bus.armed, 1);
        tick();
        chk("to_timeout", bus.timeout, 1);
        chk("to_armed", bus.armed, 0);
        chk("to_valid", bus.valid, 0);
        bus.arm = 1'b1;
        tick(2);
        bus.arm = 1'b0;
        chk("to_arm_ignored", bus.timeout, 1);
        clear(0);
        chk("clr_timeout", bus.timeout, 0);
        tick(4);

        // edge landing on the timeout cycle wins
        arm_round();
        tick(4);
        bus.pb = 4'b0001;
        tick(3);
        chk("race_early", bus.valid, 0);
        tick();
        chk("race_valid", bus.valid, 1);
        chk("race_timeout", bus.timeout, 0);
        chk("race_winner", bus.winner, 0);
        clear(4);

`ifdef PBA_FALSE_START_EN
        bus.pb = 4'b0001;
        tick(4);
        chk("fs_flag", bus.false_start, 4'b0001);
        bus.pb = '0;
        tick(3);
        arm_round();
        bus.pb = 4'b0011;
        tick(4);
        chk("fs_valid", bus.valid, 1);
        chk("fs_winner", bus.winner, 1);
        chk("fs_tie", bus.tie, 0);
        chk("fs_onehot", bus.winner_onehot, 4'b0010);
        clear(0);
        chk("fs_clr", bus.false_start, 0);
        tick(4);
`else
        // button held across arm must not win; a fresh press does
        bus.pb = 4'b0001;
        tick(4);
        chk("fs_off", bus.false_start, 0);
        arm_round();
        tick();
        chk("held_valid", bus.valid, 0);
        chk("held_armed", bus.armed, 1);
        bus.pb = '0;
        tick(2);
        bus.pb = 4'b0001;
        tick(4);
        chk("repress_valid", bus.valid, 1);
        chk("repress_winner", bus.winner, 0);
        chk("repress_onehot", bus.winner_onehot, 4'b0001);
        clear(4);
`endif

        // async reset in the middle of an armed round with all buttons down
        arm_round();
        bus.pb = 4'b1111;
        tick(3);
        chk("pre_rst_armed", bus.armed, 1);
        chk("pre_rst_push", bus.push, 1);
        rst = 1'b1;
        #1;
        chk("async_armed", bus.armed, 0);
        chk("async_push", bus.push, 0);
        chk("async_valid", bus.valid, 0);
        tick();
        rst = 1'b0;
        bus.pb = '0;
        tick();
        chk("post_rst_armed", bus.armed, 0);
        chk("post_rst_valid", bus.valid, 0);
        chk("post_rst_onehot", bus.winner_onehot, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pb_arbiter.md
# pb_arbiter

N-player push-button first-press arbiter for the tug-of-war game, generalising the two-player latch to a parametrised, fully clocked block. Buttons are synchronised and edge-detected, a round is armed explicitly, the first rising edge(s) after arming decide the winner or a tie, and an unanswered round ends in a timeout. It sits between the debounced button inputs and the game-score/rope-position logic, which consumes `winner`/`tie`/`valid` and pulses `clr` to start the next round.

## Interface
- `N`, 2: number of players/buttons, legal range 2..16.
- `SYNC_STAGES`, 2: synchroniser flops per button, legal range 2..4.
- `TIMEOUT`, 1000: cycles in ARMED before declaring timeout; 0 disables the timeout.
- Derived `WW` = max(1, clog2(N)); counter width = clog2(TIMEOUT+1), minimum 1.

- `clk` in 1: single clock, all flops rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `clr` in 1: synchronous clear; returns block to IDLE.
- `arm` in 1: start a round (sampled in IDLE only).
- `pb` in N: raw button inputs, asynchronous, active-high.
- `push` out 1: OR of synchronised buttons.
- `armed` out 1: high while in ARMED.
- `valid` out 1: high in DECIDED.
- `winner` out WW: index of winning channel.
- `winner_onehot` out N: one-hot winner (all edges on a tie).
- `tie` out 1: more than one channel edged in the deciding cycle.
- `timeout` out 1: high in TIMEOUT.
- `false_start` out N: sticky early-press flags (see Configuration).

## Operation
- Sync: each `pb[i]` through `SYNC_STAGES` flops → `s[i]`; `prev[i]` = `s[i]` delayed one cycle; edge `e[i]` = `s[i] & ~prev[i]`. Buttons already held at arm time never win; a fresh rising edge is required.
- Eligible edges `E` = `e & ~mask` (mask = `false_start` when macro enabled, else 0).
- States: IDLE, ARMED, DECIDED, TIMEOUT.
- IDLE: `arm`=1 → ARMED, counter ← 0. Outputs `valid`/`tie`/`timeout` low.
- ARMED: `E`≠0 → DECIDED; `winner_onehot` ← `E`; `winner` ← lowest set index of `E`; `tie` ← (popcount(`E`) > 1). Else if `TIMEOUT`≠0 and counter = `TIMEOUT`−1 → TIMEOUT. Else counter increments.
- DECIDED, TIMEOUT: all result outputs held; button activity ignored; wait for `clr`.
- Priority: `rst` > `clr` > state transitions. `clr` in any state → IDLE, clears `winner`, `winner_onehot`, `tie`, counter, `false_start`. `clr` and `arm` in the same cycle → IDLE (arm dropped).
- `arm` outside IDLE ignored.
- Edge and timeout in the same cycle: edge wins (DECIDED).
- Reset values: state IDLE; all sync/prev flops 0; `push`, `armed`, `valid`, `tie`, `timeout` 0; `winner` 0; `winner_onehot` 0; `false_start` 0; counter 0.

## Timing
- `pb` rising → `e` high `SYNC_STAGES`+1 cycles after first sampling edge (sync + prev).
- `e` in ARMED → `valid`, `winner`, `tie` registered next edge (1 cycle).
- `arm` in IDLE → `armed` high next cycle; timeout asserts exactly `TIMEOUT` cycles after `armed` rises when no eligible edge.
- `clr` → IDLE and all results cleared next cycle.
- `push` is registered off `s`, one cycle after `s`.

## Configuration
- `PBA_FALSE_START_EN` defined: in IDLE, any `e[i]` sets sticky `false_start[i]`; in ARMED, flagged channels are masked from `E` (cannot win or tie). If all channels are flagged the round can end only by timeout or `clr`. Flags clear on `clr`/`rst` only.
- Not defined: `false_start` tied to 0, no masking, no flag flops.

## Test plan
- Reset: assert `rst` mid-ARMED with `pb`=all ones → all outputs 0, state IDLE, `armed`=0 next cycle.
- N=4, arm, press `pb[2]` alone → `valid`=1, `winner`=2, `winner_onehot`=0100, `tie`=0, exactly SYNC_STAGES+2 cycles after press.
- N=4, arm, press `pb[1]` and `pb[3]` same cycle → `tie`=1, `winner`=1, `winner_onehot`=1010; later presses ignored until `clr`.
- TIMEOUT=8, arm, no press → `timeout`=1 exactly 8 cycles after `armed`; press arriving as edge on cycle 8 → DECIDED instead.
- Hold `pb[0]` before `arm`, keep held → no win; release and re-press → `winner`=0.
- With `PBA_FALSE_START_EN`, N=2: press `pb[0]` in IDLE → `false_start`=01; arm, press both together → `winner`=1, `tie`=0; `clr` → `false_start`=00.
